alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue stage that feeds the execute-stage ALU.
- Accepts a raw RV32I instruction word plus register-file read values over a valid/ready handshake.
- Decodes the instruction into the ALU's 4-bit operation code and operand pair, then registers the result into a one-deep ID/EX pipeline slot.
- Flags encodings the ALU cannot execute and counts them.

Parameters:
CNT_W, 16, width of the saturating illegal-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction this cycle
in_instr  in  32  instruction word
in_rs1_val  in  32  rs1 register value
in_rs2_val  in  32  rs2 register value
flush  in  1  synchronous pipeline kill
out_valid  out  1  issued operation valid
out_ready  in  1  ALU/EX stage accepts the operation
out_a  out  32  ALU operand A
out_b  out  32  ALU operand B (rs2 value or sign-extended immediate)
out_alu_ctrl  out  4  ALU op code: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7
out_rd  out  5  destination register index
out_wb_en  out  1  writeback enable
out_illegal  out  1  instruction not executable by the ALU
illegal_cnt  out  CNT_W  count of illegal instructions issued

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, all out_* payload=0, illegal_cnt=0. Reset mid-transfer discards the slot content.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* signals hold stable.
- in_ready = !flush && (!out_valid || out_ready). This path is combinational to out_ready in the base build.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1.
- Slot update:
  - On input transfer, load the decoded payload and set out_valid=1.
  - On output transfer with no input transfer, clear out_valid.
  - On simultaneous input and output transfers, replace the payload and keep out_valid=1.
- Flush: synchronous, highest priority after reset. Next cycle out_valid=0; any input presented during flush is not accepted; illegal_cnt is unchanged by the killed slot.
- Decode, opcode 0110011 (R-type), by funct7/funct3:
  - 0000000/000 -> ADD; 0100000/000 -> SUB
  - 0000000/111 -> AND; 0000000/110 -> OR; 0000000/100 -> XOR
  - 0000000/010 -> SLT; 0000000/001 -> SLL; 0000000/101 -> SRL
  - out_b = in_rs2_val.
- Decode, opcode 0010011 (I-ALU), by funct3:
  - 000 -> ADD; 111 -> AND; 110 -> OR; 100 -> XOR; 010 -> SLT.
  - 001 with instr[31:25]=0 -> SLL; 101 with instr[31:25]=0 -> SRL.
  - out_b = sign-extended instr[31:20].
- All ops: out_a = in_rs1_val; out_rd = instr[11:7].
- Illegal: any other opcode, SLTU/SLTIU (funct3 011), SRA/SRAI (funct7 0100000 with funct3 101), or a nonzero funct7 on other R-type ops. Illegal payload: out_illegal=1, out_wb_en=0, out_alu_ctrl=ADD, out_a=out_b=0, out_rd=0.
- out_wb_en = legal && rd != 0.
- illegal_cnt increments by 1 on each input transfer carrying an illegal instruction and saturates at all-ones (no wrap).

Optional Feature:
- Macro ALU_ISSUE_SKID_EN.
- Defined: a one-entry skid register is added, and in_ready becomes a registered signal equal to "skid empty", with no combinational path from out_ready.
  - An input arriving while the slot is stalled goes to the skid; in_ready drops the next cycle.
  - When the slot drains, the skid content moves into the slot in the same edge, preserving order.
  - Flush clears both slot and skid.
  - Steady-state throughput stays at 1 instruction/cycle.
- Undefined: behaviour exactly as above, with no skid register.

Test Plan:
- Reset release, then in_instr=0x00208033 (add x0,x1,x2), rs1=5, rs2=7 -> next cycle out_valid=1, alu_ctrl=0, out_a=5, out_b=7, out_wb_en=0 (rd=x0).
- Instruction 0xFFF0A093 (slti x1,x1,-1), rs1=3 -> alu_ctrl=5, out_b=0xFFFFFFFF, out_rd=1, out_wb_en=1.
- Instruction 0x4020D0B3 (sra) -> out_illegal=1, out_wb_en=0, alu_ctrl=0, out_a=out_b=0, illegal_cnt 0->1; 3 more illegal instructions -> illegal_cnt=4.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0 (skid build: exactly one extra instruction is accepted); release -> instructions emerge in order with none lost or duplicated.
- Assert flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not consumed, illegal_cnt unchanged.
- Continuous in_valid/out_ready=1 over 100 random legal R/I instructions -> one output per cycle, each matching the reference decode model.

Source files
------------

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decode into ALU op/operands, one-deep ID/EX slot.
// Optional skid buffer (registered in_ready) under `ALU_ISSUE_SKID_EN.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [3:0]       out_alu_ctrl,
  output logic [4:0]       out_rd,
  output logic             out_wb_en,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic        illegal;
    logic        wb_en;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } pl_t;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] XOR = 4'd4;
  localparam logic [3:0] SLT = 4'd5;
  localparam logic [3:0] SLL = 4'd6;
  localparam logic [3:0] SRL = 4'd7;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r;
  logic       is_i;
  logic       legal;
  logic [3:0] ctrl;
  pl_t        dec;
  logic       unused_rs_fields;

  assign opc  = in_instr[6:0];
  assign f3   = in_instr[14:12];
  assign f7   = in_instr[31:25];
  assign is_r = (opc == 7'b0110011);
  assign is_i = (opc == 7'b0010011);
  assign unused_rs_fields = ^in_instr[19:15];

  always_comb begin
    legal = 1'b0;
    ctrl  = ADD;
    unique case (1'b1)
      is_r: begin
        legal = 1'b1;
        unique case ({f7, f3})
          10'b0000000_000: ctrl = ADD;
          10'b0100000_000: ctrl = SUB;
          10'b0000000_111: ctrl = AND;
          10'b0000000_110: ctrl = OR;
          10'b0000000_100: ctrl = XOR;
          10'b0000000_010: ctrl = SLT;
          10'b0000000_001: ctrl = SLL;
          10'b0000000_101: ctrl = SRL;
          default:         legal = 1'b0;
        endcase
      end
      is_i: begin
        legal = 1'b1;
        unique case (f3)
          3'b000:  ctrl = ADD;
          3'b111:  ctrl = AND;
          3'b110:  ctrl = OR;
          3'b100:  ctrl = XOR;
          3'b010:  ctrl = SLT;
          3'b001:  begin ctrl = SLL; legal = (f7 == 7'd0); end
          3'b101:  begin ctrl = SRL; legal = (f7 == 7'd0); end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings issue as a zeroed, non-writing ADD.
  always_comb begin
    dec         = '0;
    dec.illegal = !legal;
    if (legal) begin
      dec.ctrl  = ctrl;
      dec.a     = in_rs1_val;
      dec.b     = is_r ? in_rs2_val
                       : {{20{in_instr[31]}}, in_instr[31:20]};
      dec.rd    = in_instr[11:7];
      dec.wb_en = (in_instr[11:7] != 5'd0);
    end
  end

  pl_t              slot_q, slot_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire;
  logic             out_fire;

  assign out_fire = valid_q && out_ready;
  assign in_fire  = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  pl_t  skid_q, skid_d;
  logic skid_v_q, skid_v_d;
  logic slot_free;

  assign slot_free = !valid_q || out_ready;
  assign in_ready  = !skid_v_q && !flush;

  always_comb begin
    slot_d   = slot_q;
    valid_d  = valid_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      valid_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (slot_free) begin
        slot_d   = skid_q;
        valid_d  = 1'b1;
        skid_v_d = 1'b0;
      end
    end else if (in_fire) begin
      if (slot_free) begin
        slot_d  = dec;
        valid_d = 1'b1;
      end else begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end
`else
  assign in_ready = !flush && (!valid_q || out_ready);

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_fire) begin
      slot_d  = dec;
      valid_d = 1'b1;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && dec.illegal && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_a        = slot_q.a;
  assign out_b        = slot_q.b;
  assign out_alu_ctrl = slot_q.ctrl;
  assign out_rd       = slot_q.rd;
  assign out_wb_en    = slot_q.wb_en;
  assign out_illegal  = slot_q.illegal;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases plus random
// legal streams against a table-driven decode model.
module tb_alu_issue;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [31:0]   in_rs1_val;
  logic [31:0]   in_rs2_val;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_a;
  logic [31:0]   out_b;
  logic [3:0]    out_alu_ctrl;
  logic [4:0]    out_rd;
  logic          out_wb_en;
  logic          out_illegal;
  logic [CW-1:0] illegal_cnt;

  int n_run  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  alu_issue #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_val(in_rs1_val),
    .in_rs2_val(in_rs2_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ill;
    logic        wb;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  // Op lookup by funct3; -1 marks the unsupported SLTU/SLTIU slot.
  function automatic exp_t ref_model(input logic [31:0] ins,
                                     input logic [31:0] rs1,
                                     input logic [31:0] rs2);
    int   tbl [8];
    int   op;
    exp_t e;
    tbl = '{0, 6, 5, -1, 4, 7, 3, 2};
    op  = -1;
    e   = '0;
    if (ins[6:0] == 7'h33) begin
      if (ins[31:25] == 7'h00) op = tbl[ins[14:12]];
      else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd0) op = 1;
      e.b = rs2;
    end else if (ins[6:0] == 7'h13) begin
      op = tbl[ins[14:12]];
      if ((ins[14:12] == 3'd1 || ins[14:12] == 3'd5) && ins[31:25] != 7'd0)
        op = -1;
      e.b = {{20{ins[31]}}, ins[31:20]};
    end
    if (op < 0) begin
      e     = '0;
      e.ill = 1'b1;
    end else begin
      e.ctrl = 4'(op);
      e.a    = rs1;
      e.rd   = ins[11:7];
      e.wb   = (ins[11:7] != 5'd0);
    end
    return e;
  endfunction

  function automatic exp_t obs();
    return {out_illegal, out_wb_en, out_alu_ctrl, out_a, out_b, out_rd};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic [2:0]  f3;
    w  = $urandom;
    f3 = 3'($urandom_range(0, 7));
    if (f3 == 3'd3) f3 = 3'd0;
    w[14:12] = f3;
    if ($urandom_range(0, 1) == 1) begin
      w[6:0]   = 7'h33;
      w[31:25] = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else begin
      w[6:0] = 7'h13;
      if (f3 == 3'd1 || f3 == 3'd5) w[31:25] = 7'h00;
    end
    return w;
  endfunction

  function automatic void bump_cnt();
    if (exp_cnt < (1 << CW) - 1) exp_cnt++;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs1_val = '0; in_rs2_val = '0;
    repeat (2) @(negedge clk);
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_run++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_payload: got %h want 0", obs());
    end
    n_run++;
    if (illegal_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", illegal_cnt);
    end
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_add();
    in_instr = 32'h00208033; in_rs1_val = 32'd5; in_rs2_val = 32'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_run++;
    if (out_valid !== 1'b1 || out_alu_ctrl !== 4'd0) begin
      n_fail++;
      $display("FAIL add_ctrl: got v=%b c=%0d want v=1 c=0", out_valid, out_alu_ctrl);
    end
    n_run++;
    if (out_a !== 32'd5 || out_b !== 32'd7) begin
      n_fail++; $display("FAIL add_ops: got %h/%h want 5/7", out_a, out_b);
    end
    n_run++;
    if (out_wb_en !== 1'b0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wb: got wb=%b rd=%0d ill=%b want 0/0/0", out_wb_en, out_rd, out_illegal);
    end
  endtask

  task automatic test_slti();
    in_instr = 32'hFFF0A093; in_rs1_val = 32'd3; in_rs2_val = $urandom;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_run++;
    if (out_alu_ctrl !== 4'd5 || out_b !== 32'hFFFFFFFF || out_a !== 32'd3) begin
      n_fail++;
      $display("FAIL slti_ops: got c=%0d a=%h b=%h want 5/3/ffffffff", out_alu_ctrl, out_a, out_b);
    end
    n_run++;
    if (out_rd !== 5'd1 || out_wb_en !== 1'b1) begin
      n_fail++; $display("FAIL slti_wb: got rd=%0d wb=%b want 1/1", out_rd, out_wb_en);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ill [4];
    exp_t        e;
    ill = '{32'h4020D0B3, 32'h0020B033, 32'h0010B093, 32'h0220F033};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = ill[i]; in_rs1_val = $urandom | 1; in_rs2_val = $urandom | 1;
      in_valid = 1'b1;
      @(negedge clk);
      bump_cnt();
      e = '0; e.ill = 1'b1;
      n_run++;
      if (obs() !== e || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL illegal_payload: got %h want %h", obs(), e);
      end
      n_run++;
      if (illegal_cnt !== CW'(exp_cnt)) begin
        n_fail++; $display("FAIL illegal_cnt: got %0d want %0d", illegal_cnt, exp_cnt);
      end
    end
    in_valid = 1'b0;
    n_run++;
    if (illegal_cnt !== CW'(4)) begin
      n_fail++; $display("FAIL illegal_cnt4: got %0d want 4", illegal_cnt);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_instr = rand_legal(); in_rs1_val = $urandom; in_rs2_val = $urandom;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre: got %b want 1", out_valid);
    end
    flush = 1'b1; in_instr = 32'h4020D0B3;
    #1;
    n_run++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    n_run++;
    if (illegal_cnt !== CW'(exp_cnt)) begin
      n_fail++; $display("FAIL flush_cnt: got %0d want %0d", illegal_cnt, exp_cnt);
    end
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_consumed: got %b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    exp_t        q [$];
    exp_t        snap;
    exp_t        e;
    logic [31:0] ci, ca, cb;
    logic        ia, oa;
    int          acc, emit, acc_st, want_st;
    acc = 0; emit = 0; acc_st = 0;
`ifdef ALU_ISSUE_SKID_EN
    want_st = 1;
`else
    want_st = 0;
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    ci = rand_legal(); ca = $urandom; cb = $urandom;
    snap = '0;
    for (int c = 0; c < 20; c++) begin
      in_instr = ci; in_rs1_val = ca; in_rs2_val = cb;
      in_valid  = (c < 10);
      out_ready = !(c >= 1 && c <= 3);
      #1;
      ia = in_valid && in_ready;
      oa = out_valid && out_ready;
      if (c >= 1 && c <= 3) begin
        if (c == 1) snap = obs();
        else begin
          n_run++;
          if (obs() !== snap || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_stable: got %h want %h", obs(), snap);
          end
        end
        if (ia) acc_st++;
`ifndef ALU_ISSUE_SKID_EN
        n_run++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
`endif
      end
      if (oa) begin
        emit++;
        n_run++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: got %h want none", obs());
        end else begin
          e = q.pop_front();
          if (obs() !== e) begin
            n_fail++; $display("FAIL stall_order: got %h want %h", obs(), e);
          end
        end
      end
      if (ia) begin
        acc++;
        q.push_back(ref_model(ci, ca, cb));
        ci = rand_legal(); ca = $urandom; cb = $urandom;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_run++;
    if (q.size() != 0 || acc != emit) begin
      n_fail++; $display("FAIL stall_lost: got emit=%0d want %0d", emit, acc);
    end
    n_run++;
    if (acc_st != want_st) begin
      n_fail++; $display("FAIL stall_accept: got %0d want %0d", acc_st, want_st);
    end
  endtask

  task automatic test_stream();
    exp_t        prev;
    logic [31:0] w, a, b;
    prev = '0;
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      w = rand_legal(); a = $urandom; b = $urandom;
      in_instr = w; in_rs1_val = a; in_rs2_val = b; in_valid = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready: got %b want 1", in_ready);
      end
      if (i > 0) begin
        n_run++;
        if (out_valid !== 1'b1 || obs() !== prev) begin
          n_fail++;
          $display("FAIL stream_out: got v=%b %h want %h", out_valid, obs(), prev);
        end
      end
      prev = ref_model(w, a, b);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_run++;
    if (out_valid !== 1'b1 || obs() !== prev) begin
      n_fail++; $display("FAIL stream_last: got %h want %h", obs(), prev);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instr = {25'($urandom), 7'b0000011};
      in_valid = 1'b1;
      @(negedge clk);
      bump_cnt();
      n_run++;
      if (illegal_cnt !== CW'(exp_cnt)) begin
        n_fail++; $display("FAIL sat_cnt: got %0d want %0d", illegal_cnt, exp_cnt);
      end
    end
    in_valid = 1'b0;
    n_run++;
    if (illegal_cnt !== CW'((1 << CW) - 1)) begin
      n_fail++; $display("FAIL sat_max: got %0d want %0d", illegal_cnt, (1 << CW) - 1);
    end
  endtask

  task automatic test_reset_mid();
    in_instr = rand_legal(); in_rs1_val = $urandom; in_rs2_val = $urandom;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_run++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    n_run++;
    if (out_valid !== 1'b0 || obs() !== '0) begin
      n_fail++; $display("FAIL rmid_slot: got v=%b %h want 0", out_valid, obs());
    end
    n_run++;
    if (illegal_cnt !== CW'(exp_cnt)) begin
      n_fail++; $display("FAIL rmid_cnt: got %0d want 0", illegal_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_post: got %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_slti();
    test_illegal();
    test_flush();
    test_stall();
    test_stream();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
